// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU, M-extension, branch and
// forwarding selects, plus the multiply/divide sequencer states.
package ex_pkg;

    localparam int DEFAULT_XLEN = 32;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_SLL   = 4'b0010;
    localparam logic [3:0] ALU_SLT   = 4'b0011;
    localparam logic [3:0] ALU_SLTU  = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_OR    = 4'b1000;
    localparam logic [3:0] ALU_AND   = 4'b1001;
    localparam logic [3:0] ALU_LUI   = 4'b1010;
    localparam logic [3:0] ALU_AUIPC = 4'b1011;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M unit: latency-counted multiplier and a restoring
// divider on magnitudes with sign fix-up applied when the result is presented.
module muldiv_unit
    import ex_pkg::*;
#(
    parameter int XLEN        = DEFAULT_XLEN,
    parameter int MUL_LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            ready_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CMAX = (XLEN > MUL_LATENCY) ? XLEN : MUL_LATENCY;
    localparam int CW   = $clog2(CMAX + 1);

    md_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic [XLEN-1:0]   quo_q, rem_q, div_q;
    logic              negq_q, negr_q;

    logic              sgn, is_rem, div_zero, div_ovf;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [XLEN:0]     rem_sh, diff;
    logic [XLEN-1:0]   iter_rem, iter_quo;
    logic              a_sgn, b_sgn;
    logic [2*XLEN-1:0] ext_a, ext_b, prod;

    assign sgn      = ~op_q[0];
    assign is_rem   = op_q[1];
    assign div_zero = (b_q == '0);
    assign div_ovf  = sgn && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
    assign abs_a    = (sgn && a_q[XLEN-1]) ? (~a_q + 1'b1) : a_q;
    assign abs_b    = (sgn && b_q[XLEN-1]) ? (~b_q + 1'b1) : b_q;

    // One restoring step: shift in the next dividend bit, keep the difference if it did not borrow.
    assign rem_sh   = {rem_q, quo_q[XLEN-1]};
    assign diff     = rem_sh - {1'b0, div_q};
    assign iter_rem = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    assign iter_quo = {quo_q[XLEN-2:0], ~diff[XLEN]};

    assign a_sgn = (op_q == MD_MULH) || (op_q == MD_MULHSU);
    assign b_sgn = (op_q == MD_MULH);
    assign ext_a = {{XLEN{a_sgn & a_q[XLEN-1]}}, a_q};
    assign ext_b = {{XLEN{b_sgn & b_q[XLEN-1]}}, b_q};
    assign prod  = ext_a * ext_b;

    assign ready_o = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign done_o  = (state_q == ST_DONE);

    always_comb begin
        result_o = '0;
        if (op_q[2]) begin
            if (is_rem) result_o = negr_q ? (~rem_q + 1'b1) : rem_q;
            else        result_o = negq_q ? (~quo_q + 1'b1) : quo_q;
        end else if (op_q == MD_MUL) begin
            result_o = prod[XLEN-1:0];
        end else begin
            result_o = prod[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start_i) begin
                    cnt_d = '0;
                    if (op_i[2])               state_d = ST_DIV;
                    else if (MUL_LATENCY <= 1) state_d = ST_DONE;
                    else                       state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                cnt_d = cnt_q + 1'b1;
                if (int'(cnt_q) >= MUL_LATENCY - 2) state_d = ST_DONE;
            end
            ST_DIV: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '0) begin
                    if (div_zero || div_ovf) state_d = ST_DONE;
                end else if (cnt_q == CW'(XLEN)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Count 0 of DIV prepares magnitudes (or the special-case result); counts 1..XLEN iterate.
    always_ff @(posedge clk) begin
        if (start_i) begin
            op_q <= op_i;
            a_q  <= a_i;
            b_q  <= b_i;
        end else if (state_q == ST_DIV) begin
            if (cnt_q == '0) begin
                if (div_zero) begin
                    quo_q  <= '1;
                    rem_q  <= a_q;
                    negq_q <= 1'b0;
                    negr_q <= 1'b0;
                end else if (div_ovf) begin
                    quo_q  <= a_q;
                    rem_q  <= '0;
                    negq_q <= 1'b0;
                    negr_q <= 1'b0;
                end else begin
                    quo_q  <= abs_a;
                    rem_q  <= '0;
                    div_q  <= abs_b;
                    negq_q <= sgn & (a_q[XLEN-1] ^ b_q[XLEN-1]);
                    negr_q <= sgn & a_q[XLEN-1];
                end
            end else begin
                quo_q <= iter_quo;
                rem_q <= iter_rem;
            end
        end
    end

endmodule

// File: rtl/ex_stage_m.sv
// Execute stage: forwarding muxes, ALU, branch comparator and registered
// results; M-extension ops are handed to muldiv_unit and stall the front end.
module ex_stage_m
    import ex_pkg::*;
#(
    parameter int XLEN        = DEFAULT_XLEN,
    parameter int MUL_LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [3:0]      alu_op,
    input  logic            alu_src,
    input  logic            md_en,
    input  logic [2:0]      md_op,
    input  logic            branch,
    input  logic [2:0]      br_funct,
    input  logic [1:0]      forward_a,
    input  logic [1:0]      forward_b,
    input  logic [XLEN-1:0] ex_mem_alu_result,
    input  logic [XLEN-1:0] mem_wb_result,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] alu_result,
    output logic            zero_flag,
    output logic [XLEN-1:0] branch_target,
    output logic            branch_taken,
    output logic            stall
);

    localparam int SHW = $clog2(XLEN);

    function automatic logic [XLEN-1:0] fwd_sel(input logic [1:0] sel,
                                                input logic [XLEN-1:0] reg_v,
                                                input logic [XLEN-1:0] exm_v,
                                                input logic [XLEN-1:0] mwb_v);
        case (sel)
            FWD_EXMEM: return exm_v;
            FWD_MEMWB: return mwb_v;
            default:   return reg_v;
        endcase
    endfunction

    logic            accept, md_start, md_ready, md_done;
    logic [XLEN-1:0] md_result;
    logic [XLEN-1:0] op_a, rs2_fwd, op_b;

    logic            vld_p0;
    logic [XLEN-1:0] a_p0, b_p0, rs2_p0, tgt_p0;
    logic [3:0]      alu_op_p0;
    logic            branch_p0;
    logic [2:0]      br_funct_p0;

    logic [XLEN-1:0] alu_res;
    logic [SHW-1:0]  shamt;
    logic            eq, lt_s, lt_u, cond;

    logic            out_valid_q, zero_q, taken_q;
    logic [XLEN-1:0] result_q, target_q;

    assign in_ready = md_ready;
    assign stall    = in_valid & ~in_ready;
    assign accept   = in_valid & in_ready & ~flush;
    assign md_start = accept & md_en;

    assign op_a    = fwd_sel(forward_a, rs1_data, ex_mem_alu_result, mem_wb_result);
    assign rs2_fwd = fwd_sel(forward_b, rs2_data, ex_mem_alu_result, mem_wb_result);
    assign op_b    = (alu_src && !md_en) ? imm : rs2_fwd;

    muldiv_unit #(
        .XLEN        (XLEN),
        .MUL_LATENCY (MUL_LATENCY)
    ) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (md_start),
        .flush_i  (flush),
        .op_i     (md_op),
        .a_i      (op_a),
        .b_i      (rs2_fwd),
        .ready_o  (md_ready),
        .done_o   (md_done),
        .result_o (md_result)
    );

    // Stage p0: operands resolved and latched at acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p0 <= 1'b0;
        else        vld_p0 <= accept & ~md_en;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0        <= op_a;
            b_p0        <= op_b;
            rs2_p0      <= rs2_fwd;
            tgt_p0      <= pc + imm;
            alu_op_p0   <= alu_op;
            branch_p0   <= branch;
            br_funct_p0 <= br_funct;
        end
    end

    assign shamt = b_p0[SHW-1:0];
    assign eq    = (a_p0 == rs2_p0);
    assign lt_s  = ($signed(a_p0) < $signed(rs2_p0));
    assign lt_u  = (a_p0 < rs2_p0);

    always_comb begin
        alu_res = '0;
        case (alu_op_p0)
            ALU_ADD:   alu_res = a_p0 + b_p0;
            ALU_SUB:   alu_res = a_p0 - b_p0;
            ALU_SLL:   alu_res = a_p0 << shamt;
            ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(a_p0) < $signed(b_p0))};
            ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (a_p0 < b_p0)};
            ALU_XOR:   alu_res = a_p0 ^ b_p0;
            ALU_SRL:   alu_res = a_p0 >> shamt;
            ALU_SRA:   alu_res = $signed(a_p0) >>> shamt;
            ALU_OR:    alu_res = a_p0 | b_p0;
            ALU_AND:   alu_res = a_p0 & b_p0;
            ALU_LUI:   alu_res = b_p0;
            ALU_AUIPC: alu_res = tgt_p0;
            default:   alu_res = '0;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (br_funct_p0)
            BR_EQ:   cond = eq;
            BR_NE:   cond = ~eq;
            BR_LT:   cond = lt_s;
            BR_GE:   cond = ~lt_s;
            BR_LTU:  cond = lt_u;
            BR_GEU:  cond = ~lt_u;
            default: cond = 1'b0;
        endcase
    end

    // Stage p1: result registers, written by either the ALU path or a finished MD op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            target_q    <= '0;
            taken_q     <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (!flush) begin
                if (vld_p0) begin
                    out_valid_q <= 1'b1;
                    result_q    <= alu_res;
                    zero_q      <= (alu_res == '0);
                    target_q    <= tgt_p0;
                    taken_q     <= branch_p0 & cond;
                end else if (md_done) begin
                    out_valid_q <= 1'b1;
                    result_q    <= md_result;
                    zero_q      <= (md_result == '0);
                    target_q    <= tgt_p0;
                    taken_q     <= 1'b0;
                end
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign alu_result    = result_q;
    assign zero_flag     = zero_q;
    assign branch_target = target_q;
    assign branch_taken  = taken_q;

endmodule

// File: tb/tb_ex_stage_m.sv
// Directed bench for ex_stage_m: ALU/forwarding, branches, MUL/DIV latency,
// divide special cases, flush and mid-operation reset.
module tb_ex_stage_m;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [3:0]  alu_op;
    logic        alu_src, md_en, branch, flush;
    logic [2:0]  md_op, br_funct;
    logic [1:0]  forward_a, forward_b;
    logic [31:0] ex_mem_alu_result, mem_wb_result;
    logic        out_valid, zero_flag, branch_taken, stall;
    logic [31:0] alu_result, branch_target;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_stage_m #(.XLEN(32), .MUL_LATENCY(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .pc                (pc),
        .rs1_data          (rs1_data),
        .rs2_data          (rs2_data),
        .imm               (imm),
        .alu_op            (alu_op),
        .alu_src           (alu_src),
        .md_en             (md_en),
        .md_op             (md_op),
        .branch            (branch),
        .br_funct          (br_funct),
        .forward_a         (forward_a),
        .forward_b         (forward_b),
        .ex_mem_alu_result (ex_mem_alu_result),
        .mem_wb_result     (mem_wb_result),
        .flush             (flush),
        .out_valid         (out_valid),
        .alu_result        (alu_result),
        .zero_flag         (zero_flag),
        .branch_target     (branch_target),
        .branch_taken      (branch_taken),
        .stall             (stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic md, input logic [3:0] aop,
                         input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b);
        in_valid  = v;
        md_en     = md;
        alu_op    = aop;
        md_op     = mop;
        rs1_data  = a;
        rs2_data  = b;
        alu_src   = 1'b0;
        branch    = 1'b0;
        br_funct  = 3'b000;
        forward_a = 2'b00;
        forward_b = 2'b00;
        imm       = 32'h0;
        pc        = 32'h0;
    endtask

    task automatic run_div(input string tag, input logic [2:0] mop, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        drive(1'b1, 1'b1, 4'h0, mop, a, b);
        tick();
        drive(1'b0, 1'b0, 4'h0, 3'b000, 32'h0, 32'h0);
        chk({tag, "_busy"}, in_ready, 1'b0);
        repeat (33) tick();
        chk({tag, "_early"}, out_valid, 1'b0);
        tick();
        chk({tag, "_vld"}, out_valid, 1'b1);
        chk({tag, "_res"}, alu_result, exp);
    endtask

    task automatic run_div_special(input string tag, input logic [2:0] mop, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] exp);
        drive(1'b1, 1'b1, 4'h0, mop, a, b);
        tick();
        drive(1'b0, 1'b0, 4'h0, 3'b000, 32'h0, 32'h0);
        tick();
        chk({tag, "_early"}, out_valid, 1'b0);
        tick();
        chk({tag, "_vld"}, out_valid, 1'b1);
        chk({tag, "_res"}, alu_result, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst_n = 1'b0;
        flush = 1'b0;
        ex_mem_alu_result = 32'h0;
        mem_wb_result     = 32'h0;
        drive(1'b0, 1'b0, 4'h0, 3'b000, 32'h0, 32'h0);
        repeat (2) tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", alu_result, 32'h0);
        chk("rst_zero", zero_flag, 1'b0);
        chk("rst_target", branch_target, 32'h0);
        chk("rst_taken", branch_taken, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        tick();

        // ADD with EX/MEM forward, then back-to-back SUB
        drive(1'b1, 1'b0, 4'b0000, 3'b000, 32'h99, 32'h3);
        forward_a = 2'b10;
        ex_mem_alu_result = 32'hA;
        tick();
        drive(1'b1, 1'b0, 4'b0001, 3'b000, 32'h5, 32'h3);
        chk("add_not_yet", out_valid, 1'b0);
        tick();
        drive(1'b0, 1'b0, 4'h0, 3'b000, 32'h0, 32'h0);
        chk("add_vld", out_valid, 1'b1);
        chk("add_res", alu_result, 32'hD);
        tick();
        chk("sub_vld", out_valid, 1'b1);
        chk("sub_res", alu_result, 32'h2);
        tick();
        chk("sub_pulse_end", out_valid, 1'b0);
        chk("sub_hold", alu_result, 32'h2);

        // MEM/WB forward on B giving zero, then SRA by immediate with masked shamt
        drive(1'b1, 1'b0, 4'b0001, 3'b000, 32'h7, 32'h1);
        forward_b = 2'b01;
        mem_wb_result = 32'h7;
        tick();
        drive(1'b1, 1'b0, 4'b0111, 3'b000, 32'h8000_0000, 32'h0);
        alu_src = 1'b1;
        imm     = 32'h24;
        tick();
        drive(1'b0, 1'b0, 4'h0, 3'b000, 32'h0, 32'h0);
        chk("fwdb_res", alu_result, 32'h0);
        chk("fwdb_zero", zero_flag, 1'b1);
        tick();
        chk("sra_res", alu_result, 32'hF800_0000);
        chk("sra_zero", zero_flag, 1'b0);

        // Branches: BNE taken, BLTU not taken, BLT taken
        drive(1'b1, 1'b0, 4'h0, 3'b000, 32'h5, 32'h6);
        branch = 1'b1; br_funct = 3'b001; pc = 32'h1000; imm = 32'h100;
        tick();
        drive(1'b1, 1'b0, 4'h0, 3'b000, 32'hFFFF_FFFF, 32'h1);
        branch = 1'b1; br_funct = 3'b110;
        tick();
        chk("bne_taken", branch_taken, 1'b1);
        chk("bne_target", branch_target, 32'h1100);
        drive(1'b1, 1'b0, 4'h0, 3'b000, 32'hFFFF_FFFF, 32'h1);
        branch = 1'b1; br_funct = 3'b100;
        tick();
        drive(1'b0, 1'b0, 4'h0, 3'b000, 32'h0, 32'h0);
        chk("bltu_taken", branch_taken, 1'b0);
        tick();
        chk("blt_taken", branch_taken, 1'b1);
        tick();

        // MULH with branch set (must not be taken), MUL presented while stalled
        drive(1'b1, 1'b1, 4'h0, 3'b001, 32'hFFFF_FFFF, 32'h2);
        branch = 1'b1; br_funct = 3'b001;
        tick();
        drive(1'b1, 1'b1, 4'h0, 3'b000, 32'h0001_0000, 32'h0001_0000);
        chk("mulh_ready_low", in_ready, 1'b0);
        chk("mulh_stall", stall, 1'b1);
        chk("mulh_early", out_valid, 1'b0);
        tick();
        chk("mulh_ready_back", in_ready, 1'b1);
        chk("mulh_no_stall", stall, 1'b0);
        tick();
        drive(1'b0, 1'b0, 4'h0, 3'b000, 32'h0, 32'h0);
        chk("mulh_vld", out_valid, 1'b1);
        chk("mulh_res", alu_result, 32'hFFFF_FFFF);
        chk("mulh_not_taken", branch_taken, 1'b0);
        chk("mul_accepted", in_ready, 1'b0);
        tick();
        chk("mul_early", out_valid, 1'b0);
        tick();
        chk("mul_vld", out_valid, 1'b1);
        chk("mul_res", alu_result, 32'h0);
        chk("mul_zero", zero_flag, 1'b1);
        tick();

        // Iterative divides
        run_div("div", 3'b100, 32'd100, 32'd7, 32'd14);
        run_div("rem", 3'b110, 32'd100, 32'd7, 32'd2);
        run_div("divneg", 3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
        run_div("remneg", 3'b110, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);

        // Special-case divides
        run_div_special("divu0", 3'b101, 32'h1234, 32'h0, 32'hFFFF_FFFF);
        run_div_special("rem0", 3'b110, 32'h1234, 32'h0, 32'h1234);
        run_div_special("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_div_special("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

        // Flush mid-DIV
        drive(1'b1, 1'b1, 4'h0, 3'b100, 32'd100, 32'd7);
        tick();
        drive(1'b0, 1'b0, 4'h0, 3'b000, 32'h0, 32'h0);
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_ready", in_ready, 1'b1);
        seen = 0;
        repeat (30) begin
            if (out_valid) seen++;
            tick();
        end
        chk("flush_no_out", seen, 0);
        drive(1'b1, 1'b0, 4'b0000, 3'b000, 32'h1, 32'h1);
        tick();
        drive(1'b0, 1'b0, 4'h0, 3'b000, 32'h0, 32'h0);
        tick();
        chk("post_flush_vld", out_valid, 1'b1);
        chk("post_flush_res", alu_result, 32'h2);
        tick();

        // Reset in the middle of a divide
        drive(1'b1, 1'b1, 4'h0, 3'b100, 32'd100, 32'd7);
        tick();
        drive(1'b0, 1'b0, 4'h0, 3'b000, 32'h0, 32'h0);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_result", alu_result, 32'h0);
        chk("mrst_valid", out_valid, 1'b0);
        chk("mrst_ready", in_ready, 1'b1);
        chk("mrst_target", branch_target, 32'h0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            if (out_valid) seen++;
            tick();
        end
        chk("mrst_no_out", seen, 0);
        drive(1'b1, 1'b0, 4'b0000, 3'b000, 32'h1, 32'h1);
        tick();
        drive(1'b0, 1'b0, 4'h0, 3'b000, 32'h0, 32'h0);
        tick();
        chk("post_rst_vld", out_valid, 1'b1);
        chk("post_rst_res", alu_result, 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
